// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared widths, owner codes and arbiter FSM states for the SRAM path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arbiter_pkg;

    // Shared with ram_ctrl and camera_ctrl so every block agrees on the SRAM geometry.
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;

    // Owner codes double as the debug digit shown on the board.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CAM  = 2'd2,
        OWN_UART = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // VGA only ever reads, the camera only ever writes, UART chooses per request.
    function automatic logic owner_is_write(input owner_t who, input logic uart_we);
        logic is_wr;
        is_wr = 1'b0;
        case (who)
            OWN_CAM:  is_wr = 1'b1;
            OWN_UART: is_wr = uart_we;
            default:  is_wr = 1'b0;
        endcase
        return is_wr;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner selection among VGA, camera and UART requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only consumes the winner while its FSM is idle.
// Ports: vga_req/cam_req/uart_req - pending requests; burst_cnt - consecutive VGA grants;
//        rr_uart - 1 when UART is next in line between cam and uart; winner - chosen owner.
module sram_arb_pick
    import sram_arbiter_pkg::*;
#(
    parameter int VGA_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             vga_req,
    input  logic             cam_req,
    input  logic             uart_req,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             rr_uart,
    output owner_t           winner
);

    logic others_pending;
    logic vga_capped;

    assign others_pending = cam_req | uart_req;
    // VGA only yields once it has used its whole burst and someone else is actually waiting.
    assign vga_capped     = (burst_cnt == CNT_W'(VGA_BURST)) && others_pending;

    always_comb begin
        winner = OWN_NONE;
        if (vga_req && !vga_capped) begin
            winner = OWN_VGA;
        end else if (cam_req && uart_req) begin
            winner = rr_uart ? OWN_UART : OWN_CAM;
        end else if (cam_req) begin
            winner = OWN_CAM;
        end else if (uart_req) begin
            winner = OWN_UART;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises single-word transactions from VGA, camera and UART onto one ram_ctrl port.
// Latency: req sampled in IDLE at N -> mem strobe at N+1; workdone at M -> done at M+1 (>= 4 cycles/txn).
// Backpressure: requesters hold req until their done pulse; a watchdog aborts a transaction stuck in WAIT.
// Ports: clk/rst - clock and async active-low reset; *_req/*_addr/*_wdata/uart_we - requester side;
//        *_done - one-cycle completion pulses; rdata - shared read data; mem_* - ram_ctrl side;
//        owner - current owner digit; err - one-cycle pulse on watchdog abort.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int VGA_BURST = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_done,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_done,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_workdone,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              err
);

    localparam int CNT_W = $clog2(VGA_BURST + 1);

    state_t           state;
    state_t           state_nxt;
    owner_t           owner_q;
    owner_t           winner;
    logic             mem_we_q;
    logic [CNT_W-1:0] burst_cnt;
    logic             rr_uart;
    logic [7:0]       wdog;
    logic             timeout;
    logic             finish;

    sram_arb_pick #(
        .VGA_BURST (VGA_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .vga_req   (vga_req),
        .cam_req   (cam_req),
        .uart_req  (uart_req),
        .burst_cnt (burst_cnt),
        .rr_uart   (rr_uart),
        .winner    (winner)
    );

    // The abort fires on the cycle the counter reaches TIMEOUT, TIMEOUT+1 cycles after the strobe.
    // It outranks a workdone arriving in the same cycle: the allowance has run out by then.
    assign timeout = (state == ST_WAIT) && (wdog == 8'(TIMEOUT));

    // Completion (normal or aborted) is a single cycle, so exactly one done fires per grant.
    assign finish    = (state == ST_DONE) || timeout;
    assign vga_done  = finish && (owner_q == OWN_VGA);
    assign cam_done  = finish && (owner_q == OWN_CAM);
    assign uart_done = finish && (owner_q == OWN_UART);
    assign err       = timeout;

    assign mem_read  = (state == ST_ISSUE) && !mem_we_q;
    assign mem_write = (state == ST_ISSUE) &&  mem_we_q;
    assign owner     = owner_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (winner != OWN_NONE) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (timeout) begin
                    state_nxt = ST_IDLE;
                end else if (mem_workdone) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and bookkeeping registers, advanced according to the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_NONE;
            mem_we_q  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            burst_cnt <= '0;
            rr_uart   <= 1'b0;
            wdog      <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A VGA gap ends its burst, so the next VGA run starts a fresh allowance.
                    if (!vga_req) begin
                        burst_cnt <= '0;
                    end
                    owner_q  <= winner;
                    mem_we_q <= owner_is_write(winner, uart_we);
                    case (winner)
                        OWN_VGA: begin
                            mem_addr  <= vga_addr;
                            mem_wdata <= '0;
                            if (burst_cnt != CNT_W'(VGA_BURST)) begin
                                burst_cnt <= burst_cnt + CNT_W'(1);
                            end
                        end
                        OWN_CAM: begin
                            mem_addr  <= cam_addr;
                            mem_wdata <= cam_wdata;
                            burst_cnt <= '0;
                            rr_uart   <= 1'b1;
                        end
                        OWN_UART: begin
                            mem_addr  <= uart_addr;
                            mem_wdata <= uart_wdata;
                            burst_cnt <= '0;
                            rr_uart   <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_ISSUE: begin
                    wdog <= 8'd0;
                end
                ST_WAIT: begin
                    if (timeout) begin
                        owner_q <= OWN_NONE;
                    end else if (mem_workdone) begin
                        // Writes leave the last read value visible.
                        if (!mem_we_q) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                ST_DONE: begin
                    owner_q <= OWN_NONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: bench for sram_arbiter with a transaction-level timing model and a ram_ctrl stub.
// Latency: n/a.
// Backpressure: requester agents hold req until done; the stub answers after a programmable delay.
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int VB = 8;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req, cam_req, uart_req, uart_we, mem_workdone;
    logic [AW-1:0] vga_addr, cam_addr, uart_addr;
    logic [DW-1:0] cam_wdata, uart_wdata, mem_rdata;
    logic          vga_done, cam_done, uart_done, mem_read, mem_write, err;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VGA_BURST(VB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_done(vga_done),
        .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_done(cam_done),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_done(uart_done), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_workdone(mem_workdone), .mem_rdata(mem_rdata),
        .owner(owner), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;

    // Transaction model: one outstanding grant described by timestamps.
    bit            m_busy;
    int            m_g;        // step in which the grant was decided (arbiter idle)
    int            m_end;      // step in which done pulses, -1 while unknown
    bit            m_abort;
    int            m_who;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    int            m_burst;
    bit            m_rr_uart;

    // Agents and stub controls.
    int            left_v, left_c, left_u;
    bit            cont_v, cont_c, cont_u;
    int            uart_we_mode;   // 0 random, 1 write, 2 read
    bit            use_fixed_vga;
    logic [AW-1:0] fixed_vga_addr;
    int            ack_mode;       // 0 lat 1..5, 1 lat 3, 2 never, 3 lat 1..6 or rarely never
    bit            use_fixed_data;
    logic [DW-1:0] fixed_data;
    bit            stray_en;
    int            wd_at;

    // Observations.
    int            n_issue, n_done, issue_base, done_base;
    int            owner_log[$];
    int            last_issue_step, last_done_step, last_err_step, last_wd_step, last_req_step;
    int            last_done_who;
    logic [AW-1:0] last_issue_addr;
    logic [DW-1:0] last_wd_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at step %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = -10; m_end = -1; m_abort = 0; m_who = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_burst = 0; m_rr_uart = 0;
        wd_at = -1;
    endtask

    // Issue at g+1, first wait step g+2 with watchdog 0, so the watchdog hits TO at g+2+TO.
    task automatic model_pre();
        if (m_busy && m_end < 0 && k == m_g + 2 + TO) begin
            m_end = k;
            m_abort = 1;
        end
    endtask

    task automatic compare();
        bit issue, fin;
        issue = m_busy && (k == m_g + 1);
        fin   = m_busy && (k == m_end);
        chk("owner",     owner,     (m_busy && k > m_g) ? m_who : 0);
        chk("mem_read",  mem_read,  issue && !m_we);
        chk("mem_write", mem_write, issue && m_we);
        chk("vga_done",  vga_done,  fin && m_who == 1);
        chk("cam_done",  cam_done,  fin && m_who == 2);
        chk("uart_done", uart_done, fin && m_who == 3);
        chk("err",       err,       fin && m_abort);
        chk("rdata",     rdata,     m_rdata);
        if (m_busy && k > m_g) begin
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic observe();
        if (mem_read || mem_write) begin
            n_issue++;
            owner_log.push_back(int'(owner));
            last_issue_step = k;
            last_issue_addr = mem_addr;
        end
        if (vga_done || cam_done || uart_done) begin
            n_done++;
            last_done_step = k;
            last_done_who = vga_done ? 1 : (cam_done ? 2 : 3);
        end
        if (err) last_err_step = k;
    endtask

    task automatic drive();
        if (vga_req && vga_done) vga_req = 1'b0;
        else if (!vga_req && left_v > 0 && (cont_v || $urandom_range(3) == 0)) begin
            vga_req = 1'b1; left_v--; last_req_step = k;
            vga_addr = use_fixed_vga ? fixed_vga_addr : AW'($urandom);
        end
        if (cam_req && cam_done) cam_req = 1'b0;
        else if (!cam_req && left_c > 0 && (cont_c || $urandom_range(3) == 0)) begin
            cam_req = 1'b1; left_c--;
            cam_addr = AW'($urandom); cam_wdata = $urandom;
        end
        if (uart_req && uart_done) uart_req = 1'b0;
        else if (!uart_req && left_u > 0 && (cont_u || $urandom_range(3) == 0)) begin
            uart_req = 1'b1; left_u--;
            uart_addr = AW'($urandom); uart_wdata = $urandom;
            uart_we = (uart_we_mode == 1) ? 1'b1 : (uart_we_mode == 2) ? 1'b0 : 1'($urandom_range(1));
        end
        if (mem_read || mem_write) begin
            case (ack_mode)
                0: wd_at = k + $urandom_range(1, 5);
                1: wd_at = k + 3;
                2: wd_at = -1;
                default: wd_at = ($urandom_range(39) == 0) ? -1 : k + $urandom_range(1, 6);
            endcase
        end
        // Stray strobes are aimed at steps where the arbiter is idle or issuing.
        mem_workdone = (k == wd_at) || (stray_en && (!m_busy || k == m_g + 1) && $urandom_range(2) == 0);
        mem_rdata = use_fixed_data ? fixed_data : $urandom;
        if (mem_workdone) begin
            last_wd_step = k;
            last_wd_data = mem_rdata;
        end
    endtask

    task automatic model_advance();
        int  who;
        bit  blocked;
        if (!m_busy) begin
            if (!vga_req) m_burst = 0;
            blocked = (m_burst == VB) && (cam_req || uart_req);
            if (vga_req && !blocked)    who = 1;
            else if (cam_req && uart_req) who = m_rr_uart ? 3 : 2;
            else if (cam_req)           who = 2;
            else if (uart_req)          who = 3;
            else                        who = 0;
            if (who != 0) begin
                m_busy = 1; m_g = k; m_end = -1; m_abort = 0; m_who = who;
                if (who == 1) begin
                    m_we = 0; m_addr = vga_addr; m_wdata = '0;
                    m_burst = (m_burst < VB) ? m_burst + 1 : VB;
                end else if (who == 2) begin
                    m_we = 1; m_addr = cam_addr; m_wdata = cam_wdata;
                    m_burst = 0; m_rr_uart = 1;
                end else begin
                    m_we = uart_we; m_addr = uart_addr; m_wdata = uart_wdata;
                    m_burst = 0; m_rr_uart = 0;
                end
            end
        end else if (k == m_end) begin
            m_busy = 0;
        end else if (m_end < 0 && k >= m_g + 2 && mem_workdone) begin
            m_end = k + 1;
            if (!m_we) m_rdata = mem_rdata;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
        model_pre();
        compare();
        observe();
        drive();
        model_advance();
    endtask

    task automatic drain(input string name);
        left_v = 0; left_c = 0; left_u = 0; cont_v = 0; cont_c = 0; cont_u = 0;
        for (int n = 0; n < 1500 && (vga_req || cam_req || uart_req || m_busy); n++) tick();
        chk(name, (vga_req || cam_req || uart_req || m_busy), 0);
        tick();
    endtask

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        vga_req = 0; cam_req = 0; uart_req = 0; uart_we = 0; mem_workdone = 0;
        vga_addr = '0; cam_addr = '0; uart_addr = '0; cam_wdata = '0; uart_wdata = '0; mem_rdata = '0;
        left_v = 0; left_c = 0; left_u = 0; cont_v = 0; cont_c = 0; cont_u = 0;
        uart_we_mode = 0; use_fixed_vga = 0; fixed_vga_addr = '0; ack_mode = 0;
        use_fixed_data = 0; fixed_data = '0; stray_en = 0;
        n_issue = 0; n_done = 0; issue_base = 0; done_base = 0;
        last_issue_step = -1; last_done_step = -1; last_err_step = -1; last_wd_step = -1;
        last_req_step = -1; last_done_who = 0; last_issue_addr = '0; last_wd_data = '0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_owner", owner, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_dones", {vga_done, cam_done, uart_done}, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;

        // Single VGA read, stub answers 3 cycles after the strobe.
        use_fixed_vga = 1; fixed_vga_addr = 20'h00010;
        use_fixed_data = 1; fixed_data = 32'hDEADBEEF;
        ack_mode = 1; left_v = 1; cont_v = 1;
        for (int n = 0; n < 40 && n_done < 1; n++) tick();
        chk("p1_done_seen", n_done, 1);
        chk("p1_strobe_latency", last_issue_step - last_req_step, 1);
        chk("p1_done_after_workdone", last_done_step - last_wd_step, 1);
        chk("p1_total_latency", last_done_step - last_req_step, 5);
        chk("p1_addr", last_issue_addr, 20'h00010);
        chk("p1_rdata", rdata, 32'hDEADBEEF);
        chk("p1_done_who", last_done_who, 1);
        use_fixed_vga = 0; use_fixed_data = 0;
        drain("p1_drain");

        // Camera and UART writes contending: strict alternation starting with camera.
        owner_log.delete();
        ack_mode = 0; uart_we_mode = 1;
        left_c = 4; left_u = 4; cont_c = 1; cont_u = 1;
        for (int n = 0; n < 300 && owner_log.size() < 4; n++) tick();
        chk("p2_bound", owner_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < owner_log.size(); i++)
            chk("p2_owner_seq", owner_log[i], (i % 2 == 0) ? 2 : 3);
        drain("p2_drain");

        // VGA and camera held: eight VGA grants, then one camera grant, repeating.
        owner_log.delete();
        left_v = 100; left_c = 100; cont_v = 1; cont_c = 1;
        for (int n = 0; n < 600 && owner_log.size() < 18; n++) tick();
        chk("p3_bound", owner_log.size() >= 18, 1);
        for (int i = 0; i < 18 && i < owner_log.size(); i++)
            chk("p3_owner_seq", owner_log[i], (i % 9 == 8) ? 2 : 1);
        drain("p3_drain");

        // Lost workdone: watchdog aborts 256 cycles after the strobe.
        ack_mode = 2; uart_we_mode = 2; left_u = 1; cont_u = 1;
        for (int n = 0; n < 400 && last_err_step < 0; n++) tick();
        chk("p4_err_seen", last_err_step >= 0, 1);
        chk("p4_err_delay", last_err_step - last_issue_step, 256);
        chk("p4_done_with_err", last_done_step, last_err_step);
        chk("p4_done_who", last_done_who, 3);
        ack_mode = 0; done_base = n_done; left_u = 1; cont_u = 1;
        for (int n = 0; n < 60 && n_done == done_base; n++) tick();
        chk("p4_recovery", n_done - done_base, 1);
        drain("p4_drain");

        // Stray workdone strobes while idle or issuing, mixed traffic.
        issue_base = n_issue; done_base = n_done;
        stray_en = 1; uart_we_mode = 0; left_v = 8; left_c = 8; left_u = 8;
        for (int n = 0; n < 2000 && (left_v + left_c + left_u) > 0; n++) tick();
        drain("p5_drain");
        chk("p5_done_per_grant", n_done - done_base, n_issue - issue_base);
        stray_en = 0;

        // Asynchronous reset while waiting on ram_ctrl.
        ack_mode = 2; left_c = 1; cont_c = 1;
        for (int n = 0; n < 50 && !(m_busy && k >= m_g + 3); n++) tick();
        chk("p6_reached_wait", m_busy && k >= m_g + 3, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("p6_owner", owner, 0);
        chk("p6_strobes", {mem_read, mem_write}, 0);
        chk("p6_dones", {vga_done, cam_done, uart_done}, 0);
        chk("p6_err", err, 0);
        chk("p6_rdata", rdata, 0);
        chk("p6_mem_addr", mem_addr, 0);
        chk("p6_mem_wdata", mem_wdata, 0);
        vga_req = 0; cam_req = 0; uart_req = 0; mem_workdone = 0;
        left_v = 0; left_c = 0; left_u = 0; cont_v = 0; cont_c = 0; cont_u = 0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        issue_base = n_issue; done_base = n_done;
        ack_mode = 0; uart_we_mode = 2; left_u = 1; cont_u = 1;
        for (int n = 0; n < 60 && n_done == done_base; n++) tick();
        chk("p6_uart_done", n_done - done_base, 1);
        chk("p6_uart_who", last_done_who, 3);
        chk("p6_uart_rdata", rdata, last_wd_data);
        drain("p6_drain");

        // Long random run with variable latency, occasional lost workdone and strays.
        ack_mode = 3; stray_en = 1; uart_we_mode = 0;
        left_v = 150; left_c = 150; left_u = 150;
        for (int n = 0; n < 20000 && (left_v + left_c + left_u) > 0; n++) tick();
        chk("p7_bound", left_v + left_c + left_u, 0);
        drain("p7_drain");
        chk("p7_done_per_grant", n_done - done_base, n_issue - issue_base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single ram_ctrl SRAM port between three requesters: the VGA scan-out reader, the camera frame writer, and the UART memory-dump/load engine.
- Sits between the requesters and ram_ctrl, on the quarter-rate clock domain.
- Serialises one word transaction at a time; VGA has priority, with a burst cap so it cannot starve the others.
- Includes a watchdog so a lost workdone cannot hang the memory path.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 32, SRAM data width
- VGA_BURST, 8, max consecutive VGA grants while another requester is pending
- TIMEOUT, 255, cycles allowed from ISSUE to workdone before abort (8-bit counter)

Ports:
- clk  in  1  quarter-rate system clock
- rst  in  1  asynchronous active-low reset
- vga_req  in  1  VGA read request; held until vga_done
- vga_addr  in  ADDR_W  VGA read address
- vga_done  out  1  one-cycle pulse; rdata valid this cycle
- cam_req  in  1  camera write request; held until cam_done
- cam_addr  in  ADDR_W  camera write address
- cam_wdata  in  DATA_W  camera write data
- cam_done  out  1  one-cycle completion pulse
- uart_req  in  1  UART request; held until uart_done
- uart_we  in  1  1=write, 0=read
- uart_addr  in  ADDR_W  UART address
- uart_wdata  in  DATA_W  UART write data
- uart_done  out  1  one-cycle completion pulse; rdata valid if read
- rdata  out  DATA_W  read data, shared by all requesters
- mem_read  out  1  to ram_ctrl read; one-cycle pulse
- mem_write  out  1  to ram_ctrl write; one-cycle pulse
- mem_addr  out  ADDR_W  to ram_ctrl inp_addr
- mem_wdata  out  DATA_W  to ram_ctrl inp_data
- mem_workdone  in  1  ram_ctrl completion pulse
- mem_rdata  in  DATA_W  ram_ctrl out_data
- owner  out  2  current owner: 0 none, 1 vga, 2 cam, 3 uart (debug digit)
- err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst=0):
  - state IDLE
  - all outputs 0; rdata 0
  - burst counter 0
  - round-robin pointer = cam
  - watchdog 0
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, pick a winner and latch addr/wdata/we into mem_* registers. Set owner, go to ISSUE. Otherwise stay.
- Arbitration:
  - VGA wins, unless vga_burst_cnt == VGA_BURST and cam_req|uart_req is high.
  - Between cam and uart: round-robin. Pointer toggles to the other after each cam/uart grant.
  - A lone requester always wins.
- Burst counter:
  - +1 on each VGA grant, saturating at VGA_BURST.
  - Cleared on any cam/uart grant.
  - Cleared in IDLE when vga_req is low.
- ISSUE: assert mem_read (VGA, or UART with we=0) or mem_write (cam, or UART with we=1) for exactly one cycle. Clear watchdog. Go to WAIT.
- WAIT: on mem_workdone, capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE. Else watchdog +1.
- Watchdog: at watchdog == TIMEOUT, pulse err, pulse the owner's done (rdata unchanged), and go to IDLE.
- DONE: pulse the owner's done for one cycle, set owner=0, go to IDLE.
- Latency:
  - req sampled in IDLE at cycle N; mem_read/mem_write high in cycle N+1.
  - workdone in cycle M gives done at M+1.
  - Minimum 4 cycles per transaction, plus ram_ctrl latency.
- mem_workdone outside WAIT is ignored (including during ISSUE).
- A requester dropping req mid-transaction does not abort; the transaction completes and done still pulses.
- A request held after its done is treated as a new request; requesters must drop req on the done cycle.
- mem_addr/mem_wdata are held stable from ISSUE through DONE.
- Exactly one done pulses per grant. done signals are never simultaneous.

Decomposition:
- Shared package:
  - owner encodings: OWN_NONE/VGA/CAM/UART
  - state encodings
  - ADDR_W/DATA_W constants, shared with ram_ctrl and camera_ctrl
- One natural sub-module, sram_arb_pick: combinational winner selection from reqs, burst count and round-robin pointer. FSM and registers stay in the top.

Test Plan:
- Single VGA read: vga_req, addr 0x00010; stub returns 0xDEADBEEF with 3-cycle workdone -> mem_read one pulse at N+1, vga_done at workdone+1, rdata=0xDEADBEEF.
- Cam and uart write (uart_we=1) held together, no VGA -> grants alternate cam, uart, cam, uart; each gets one mem_write pulse with its own addr/wdata.
- vga_req and cam_req held continuously, VGA_BURST=8 -> 8 VGA grants, then 1 cam grant, repeating; owner sequence checked.
- Stub never asserts workdone, TIMEOUT=255 -> err and owner's done pulse 256 cycles after ISSUE; next request serviced normally.
- Stray mem_workdone in IDLE/ISSUE -> no done pulse, state unaffected.
- Async reset asserted during WAIT -> all outputs 0 immediately; after release, a new uart read (we=0) completes normally.
